// File: rtl/mem_rotor_cipher.sv
// mem_rotor_cipher
// -----------------------------------------------------------------------------
// Streaming rotor cipher that sits between a character source and a character
// sink on valid/ready streams. Each accepted letter is mapped to a symbol
// index, offset by the rotor position, and substituted through the table of
// the current slot. The result is de-offset and turned back into ASCII.
// Characters that are not letters pass through unchanged. After each letter
// the rotor steps like an odometer: position first, then slot.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input stream handshake
//   in_char               input ASCII character
//   out_valid/out_ready   output stream handshake
//   out_char              output ASCII character (registered)
//   step_en               1 = rotor advances after each enciphered letter
//   key_load              load rotor from key_pos/key_slot on the next edge
//   key_pos, key_slot     rotor state to load (out-of-range loads are ignored)
//   cfg_we                table write strobe
//   cfg_slot/addr/data    table entry to write (out-of-range writes ignored)
//   cur_pos, cur_slot     registered rotor state
// -----------------------------------------------------------------------------
module mem_rotor_cipher #(
    parameter int         ALPHA     = 26,
    parameter int         SYM_W     = 5,
    parameter int         NUM_SLOTS = 4,
    parameter int         SEL_W     = 2,
    parameter logic [7:0] BASE      = 8'h41
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    input  logic             step_en,
    input  logic             key_load,
    input  logic [SYM_W-1:0] key_pos,
    input  logic [SEL_W-1:0] key_slot,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_slot,
    input  logic [SYM_W-1:0] cfg_addr,
    input  logic [SYM_W-1:0] cfg_data,
    output logic [SYM_W-1:0] cur_pos,
    output logic [SEL_W-1:0] cur_slot
);

    // Constants sized to the operands they are compared against. The
    // one-bit-wider forms let the modulo logic hold sums up to 2*ALPHA-1.
    localparam logic [7:0]       ALPHA_B   = 8'(ALPHA);
    localparam logic [SYM_W:0]   ALPHA_X   = (SYM_W+1)'(ALPHA);
    localparam logic [SYM_W-1:0] LAST_POS  = SYM_W'(ALPHA - 1);
    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_SLOTS - 1);
    localparam logic [SEL_W:0]   SLOTS_X   = (SEL_W+1)'(NUM_SLOTS);

    logic [SYM_W-1:0] tbl [NUM_SLOTS][ALPHA];
    logic [SYM_W-1:0] pos;
    logic [SEL_W-1:0] slot;

    logic             accept;
    logic [7:0]       x;
    logic             is_letter;
    logic [SYM_W-1:0] sym;
    logic [SYM_W:0]   fwd_sum;
    logic [SYM_W:0]   fwd_mod;
    logic [SYM_W-1:0] idx;
    logic [SYM_W-1:0] y;
    logic [SYM_W:0]   back_sum;
    logic [SYM_W:0]   back_mod;
    logic [SYM_W-1:0] plain;
    logic [7:0]       enc_char;

    logic             key_ok;
    logic             cfg_ok;
    logic             do_step;
    logic [SYM_W-1:0] pos_next;
    logic [SEL_W-1:0] slot_next;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign cur_pos  = pos;
    assign cur_slot = slot;

    // Letter datapath. Every modulo is a single conditional subtract, which is
    // enough because both operands of each sum are already below ALPHA.
    // Non-letters force the symbol to 0 so the table index can never leave
    // the populated range, even though their lookup result is discarded.
    always_comb begin
        x         = in_char - BASE;
        is_letter = (in_char >= BASE) && (x < ALPHA_B);
        sym       = is_letter ? x[SYM_W-1:0] : '0;
        fwd_sum   = {1'b0, sym} + {1'b0, pos};
        fwd_mod   = (fwd_sum >= ALPHA_X) ? (fwd_sum - ALPHA_X) : fwd_sum;
        idx       = fwd_mod[SYM_W-1:0];
        y         = tbl[slot][idx];
        back_sum  = {1'b0, y} + ALPHA_X - {1'b0, pos};
        back_mod  = (back_sum >= ALPHA_X) ? (back_sum - ALPHA_X) : back_sum;
        plain     = back_mod[SYM_W-1:0];
        enc_char  = is_letter ? (BASE + {{(8-SYM_W){1'b0}}, plain}) : in_char;
    end

    // Rotor next state. A valid key load wins over a step in the same cycle;
    // the character accepted in that cycle has already used the old state.
    always_comb begin
        key_ok    = key_load && ({1'b0, key_pos} < ALPHA_X) &&
                    ({1'b0, key_slot} < SLOTS_X);
        do_step   = accept && is_letter && step_en;
        pos_next  = pos;
        slot_next = slot;
        if (do_step) begin
            if (pos == LAST_POS) begin
                pos_next  = '0;
                slot_next = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
            end else begin
                pos_next = pos + 1'b1;
            end
        end
        if (key_ok) begin
            pos_next  = key_pos;
            slot_next = key_slot;
        end
    end

    // Table writes are only taken when every field is in range, so table
    // contents always stay inside the alphabet.
    always_comb begin
        cfg_ok = cfg_we && ({1'b0, cfg_addr} < ALPHA_X) &&
                 ({1'b0, cfg_data} < ALPHA_X) && ({1'b0, cfg_slot} < SLOTS_X);
    end

    // Output register and rotor state. The output holds while the sink stalls
    // and empties when the sink takes it without a new character arriving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_char  <= 8'h00;
            pos       <= '0;
            slot      <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_char  <= enc_char;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            pos  <= pos_next;
            slot <= slot_next;
        end
    end

    // Substitution tables come out of reset as the identity mapping. A write
    // lands on the edge, so a lookup in the same cycle still sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                for (int i = 0; i < ALPHA; i++) begin
                    tbl[s][i] <= SYM_W'(i);
                end
            end
        end else if (cfg_ok) begin
            tbl[cfg_slot][cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_mem_rotor_cipher.sv
// tb_mem_rotor_cipher
// -----------------------------------------------------------------------------
// Self-checking bench for mem_rotor_cipher. A behavioural model computes the
// cipher with plain integer arithmetic and a table array. A compare process
// checks the DUT against that model on every falling edge. Directed scenarios
// also pin the results to hand-worked characters and rotor states, and a
// random phase then exercises the handshake, keying and table writes.
// -----------------------------------------------------------------------------
module tb_mem_rotor_cipher;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_char;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_char;
    logic       step_en;
    logic       key_load;
    logic [4:0] key_pos;
    logic [1:0] key_slot;
    logic       cfg_we;
    logic [1:0] cfg_slot;
    logic [4:0] cfg_addr;
    logic [4:0] cfg_data;
    logic [4:0] cur_pos;
    logic [1:0] cur_slot;

    int total;
    int bad;

    // Model state.
    int         m_tbl [4][26];
    int         m_pos;
    int         m_slot;
    logic       m_valid;
    logic [7:0] m_char;

    // Characters seen leaving the DUT.
    logic [7:0] rx [$];

    mem_rotor_cipher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_char  (out_char),
        .step_en   (step_en),
        .key_load  (key_load),
        .key_pos   (key_pos),
        .key_slot  (key_slot),
        .cfg_we    (cfg_we),
        .cfg_slot  (cfg_slot),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cur_pos   (cur_pos),
        .cur_slot  (cur_slot)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point, shared by the directed and per-cycle checks.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Cipher of one character given the model's current rotor and tables.
    function automatic logic [7:0] modelEnc(input logic [7:0] c);
        int x;
        int y;
        if (c < 8'h41 || c > 8'h5A) return c;
        x = int'(c) - 65;
        y = m_tbl[m_slot][(x + m_pos) % 26];
        return 8'(65 + ((y - m_pos + 26) % 26));
    endfunction

    // Behavioural model, advanced on the same edges as the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_char  <= 8'h00;
            m_pos   <= 0;
            m_slot  <= 0;
            for (int s = 0; s < 4; s++) begin
                for (int i = 0; i < 26; i++) begin
                    m_tbl[s][i] <= i;
                end
            end
        end else begin
            if (in_valid && (!m_valid || out_ready)) begin
                m_valid <= 1'b1;
                m_char  <= modelEnc(in_char);
                if (step_en && in_char >= 8'h41 && in_char <= 8'h5A) begin
                    m_pos  <= (m_pos + 1) % 26;
                    m_slot <= (m_pos == 25) ? (m_slot + 1) % 4 : m_slot;
                end
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
            if (key_load && key_pos < 26) begin
                m_pos  <= int'(key_pos);
                m_slot <= int'(key_slot);
            end
            if (cfg_we && cfg_addr < 26 && cfg_data < 26) begin
                m_tbl[cfg_slot][cfg_addr] <= int'(cfg_data);
            end
        end
    end

    // Compare process: checks the DUT against the model each falling edge and
    // records characters the sink is about to take.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
            checkOutput("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            checkOutput("cur_pos", 32'(cur_pos), 32'(m_pos));
            checkOutput("cur_slot", 32'(cur_slot), 32'(m_slot));
            if (m_valid) checkOutput("out_char", 32'(out_char), 32'(m_char));
            if (out_valid && out_ready) rx.push_back(out_char);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rxAt(input int i);
        if (i < rx.size()) return rx[i];
        return 8'h00;
    endfunction

    // Present one character and hold it until the DUT takes it.
    task automatic applyStimulus(input logic [7:0] c);
        logic rdy;
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_char  = c;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            if (rdy) done = 1'b1;
        end
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic cfgWrite(input logic [1:0] s, input logic [4:0] a,
                            input logic [4:0] d);
        cfg_we   = 1'b1;
        cfg_slot = s;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic keyLoad(input logic [4:0] p, input logic [1:0] s);
        key_load = 1'b1;
        key_pos  = p;
        key_slot = s;
        tick();
        key_load = 1'b0;
    endtask

    task automatic drain();
        repeat (3) tick();
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        out_ready = 1'b1;
        step_en   = 1'b1;
        key_load  = 1'b0;
        key_pos   = '0;
        key_slot  = '0;
        cfg_we    = 1'b0;
        cfg_slot  = '0;
        cfg_addr  = '0;
        cfg_data  = '0;
        repeat (2) tick();
        checkOutput("reset_out_char", 32'(out_char), 32'h00);
        rst_n = 1'b1;
        tick();
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_pos", 32'(cur_pos), 32'd0);

        // Swap first two entries of table 0, then "AA" gives "BZ".
        $display("[TB] swap scenario");
        cfgWrite(2'd0, 5'd0, 5'd1);
        cfgWrite(2'd0, 5'd1, 5'd0);
        rx.delete();
        applyStimulus("A");
        applyStimulus("A");
        drain();
        checkOutput("swap_first", 32'(rxAt(0)), 32'h42);
        checkOutput("swap_second", 32'(rxAt(1)), 32'h5A);
        checkOutput("swap_pos", 32'(cur_pos), 32'd2);
        checkOutput("swap_slot", 32'(cur_slot), 32'd0);

        // Last position of last slot wraps the whole odometer.
        $display("[TB] wrap scenario");
        keyLoad(5'd25, 2'd3);
        rx.delete();
        applyStimulus("C");
        drain();
        checkOutput("wrap_char", 32'(rxAt(0)), 32'h43);
        checkOutput("wrap_pos", 32'(cur_pos), 32'd0);
        checkOutput("wrap_slot", 32'(cur_slot), 32'd0);

        // Non-letters on both sides of the alphabet pass through.
        $display("[TB] passthrough scenario");
        rx.delete();
        applyStimulus(8'h35);
        applyStimulus(8'h61);
        applyStimulus(8'h5B);
        drain();
        checkOutput("pass_digit", 32'(rxAt(0)), 32'h35);
        checkOutput("pass_lower", 32'(rxAt(1)), 32'h61);
        checkOutput("pass_bracket", 32'(rxAt(2)), 32'h5B);
        checkOutput("pass_pos", 32'(cur_pos), 32'd0);

        // Stall the sink: "A" is held, "B" waits, rotor steps only once.
        $display("[TB] backpressure scenario");
        rx.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_char   = "A";
        tick();
        in_char = "B";
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_char", 32'(out_char), 32'h42);
            checkOutput("bp_pos", 32'(cur_pos), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();
        checkOutput("bp_count", 32'(rx.size()), 32'd2);
        checkOutput("bp_first", 32'(rxAt(0)), 32'h42);
        checkOutput("bp_second", 32'(rxAt(1)), 32'h42);
        checkOutput("bp_final_pos", 32'(cur_pos), 32'd2);

        // Key load in the accept cycle: "Y" uses pos 2/slot 0 and gives "Z".
        $display("[TB] collision scenario");
        rx.delete();
        in_valid = 1'b1;
        in_char  = "Y";
        key_load = 1'b1;
        key_pos  = 5'd7;
        key_slot = 2'd2;
        tick();
        in_valid = 1'b0;
        key_load = 1'b0;
        drain();
        checkOutput("coll_char", 32'(rxAt(0)), 32'h5A);
        checkOutput("coll_pos", 32'(cur_pos), 32'd7);
        checkOutput("coll_slot", 32'(cur_slot), 32'd2);
        cfgWrite(2'd2, 5'd26, 5'd0);
        cfgWrite(2'd2, 5'd0, 5'd30);
        rx.delete();
        applyStimulus("T");
        drain();
        checkOutput("cfg_ignored", 32'(rxAt(0)), 32'h54);
        checkOutput("cfg_pos", 32'(cur_pos), 32'd8);

        // Reset mid-stream with a pending output and a modified table.
        $display("[TB] reset scenario");
        cfgWrite(2'd2, 5'd5, 5'd9);
        out_ready = 1'b0;
        applyStimulus("K");
        @(negedge clk);
        checkOutput("rst_pending", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_char", 32'(out_char), 32'h00);
        checkOutput("rst_pos", 32'(cur_pos), 32'd0);
        checkOutput("rst_slot", 32'(cur_slot), 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        rx.delete();
        applyStimulus("Q");
        applyStimulus("A");
        drain();
        checkOutput("rst_q", 32'(rxAt(0)), 32'h51);
        checkOutput("rst_identity", 32'(rxAt(1)), 32'h41);

        // Random traffic; the compare process checks every cycle.
        $display("[TB] random scenario");
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_char   = ($urandom_range(0, 9) < 7) ? 8'(8'h41 + $urandom_range(0, 25))
                                                   : 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            step_en   = ($urandom_range(0, 7) != 0);
            key_load  = ($urandom_range(0, 15) == 0);
            key_pos   = 5'($urandom_range(0, 31));
            key_slot  = 2'($urandom_range(0, 3));
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_slot  = 2'($urandom_range(0, 3));
            cfg_addr  = 5'($urandom_range(0, 31));
            cfg_data  = 5'($urandom_range(0, 31));
            tick();
        end
        in_valid  = 1'b0;
        key_load  = 1'b0;
        cfg_we    = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
